// File: rtl/snake_pkg.sv
// Shared game-controller types: FSM state encoding, heading constants and
// direction helpers used by the controller and its move-tick generator.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic is_opposite(input logic [3:0] a, input logic [3:0] b);
        return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
               ((a == DIR_DOWN)  && (b == DIR_UP))    ||
               ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
               ((a == DIR_RIGHT) && (b == DIR_LEFT));
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Step-rate divider: counts enabled cycles and pulses tick on the cycle after
// the counter wraps from TICK_DIV-1 to 0. Holding en low freezes the count.
module move_tick_gen
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    input  logic clr,
    output logic at_last,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // at_last depends on the register only, so the parent may combine it with en
    assign at_last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!nRst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (at_last) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Turns edge-detector event pulses into held game levels: state, committed
// heading, move tick, score and snake length. All outputs are registered.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 64,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               goodColl,
    input  logic               badColl,
    input  logic               button,
    input  logic [3:0]         direction,
    output logic [1:0]         state,
    output logic [3:0]         cur_dir,
    output logic               move_tick,
    output logic               grow,
    output logic [SCORE_W-1:0] score,
    output logic [6:0]         length,
    output logic               game_over
);

    if ((INIT_LEN > MAX_LEN) || (MAX_LEN > 127) || (TICK_DIV < 2)) begin : g_param_check
        $error("snake_game_ctrl: need INIT_LEN<=MAX_LEN<=127 and TICK_DIV>=2");
    end

    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [6:0] sat_inc_length(input logic [6:0] v);
        return (v >= 7'(MAX_LEN)) ? v : v + 7'd1;
    endfunction

    state_t             st_q, st_n;
    logic [3:0]         cur_dir_q, cur_dir_n;
    logic [3:0]         pend_q, pend_n;
    logic               pend_vld_q, pend_vld_n;
    logic [SCORE_W-1:0] score_q, score_n;
    logic [6:0]         length_q, length_n;
    logic               grow_q, grow_n;
    logic               go_q;
    logic               tick_en, tick_clr, at_last, tick;
    logic               dir_ok;

    move_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .nRst   (nRst),
        .en     (tick_en),
        .clr    (tick_clr),
        .at_last(at_last),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!nRst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_n;
        end
    end

    always_comb begin
        st_n       = st_q;
        cur_dir_n  = cur_dir_q;
        pend_n     = pend_q;
        pend_vld_n = pend_vld_q;
        score_n    = score_q;
        length_n   = length_q;
        grow_n     = 1'b0;
        tick_en    = 1'b0;
        tick_clr   = 1'b0;
        // Candidate turns are judged against the heading before any same-edge commit
        dir_ok     = is_onehot4(direction) && !is_opposite(direction, cur_dir_q);

        case (st_q)
            ST_IDLE: begin
                if (button) begin
                    st_n       = ST_RUN;
                    score_n    = '0;
                    length_n   = 7'(INIT_LEN);
                    cur_dir_n  = DIR_RIGHT;
                    pend_vld_n = 1'b0;
                    tick_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (badColl) begin
                    st_n = ST_OVER;
                end else begin
                    if (button) begin
                        st_n = ST_PAUSE;
                    end else begin
                        tick_en = 1'b1;
                        if (goodColl) begin
                            score_n  = sat_inc_score(score_q);
                            length_n = sat_inc_length(length_q);
                            grow_n   = 1'b1;
                        end
                        if (at_last && pend_vld_q) begin
                            cur_dir_n  = pend_q;
                            pend_vld_n = 1'b0;
                        end
                    end
                    if (dir_ok) begin
                        pend_n     = direction;
                        pend_vld_n = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (button) begin
                    st_n = ST_RUN;
                end
            end
            ST_OVER: begin
                if (button) begin
                    st_n = ST_IDLE;
                end
            end
            default: begin
                st_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            cur_dir_q  <= DIR_RIGHT;
            pend_q     <= 4'b0000;
            pend_vld_q <= 1'b0;
            score_q    <= '0;
            length_q   <= 7'(INIT_LEN);
            grow_q     <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            cur_dir_q  <= cur_dir_n;
            pend_q     <= pend_n;
            pend_vld_q <= pend_vld_n;
            score_q    <= score_n;
            length_q   <= length_n;
            grow_q     <= grow_n;
            go_q       <= (st_n == ST_OVER);
        end
    end

    assign state     = st_q;
    assign cur_dir   = cur_dir_q;
    assign move_tick = tick;
    assign grow      = grow_q;
    assign score     = score_q;
    assign length    = length_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl (TICK_DIV=4): stimulus pushes hand-computed
// expected outputs per cycle, a monitor pops and compares after each clock edge.
module tb_snake_game_ctrl;

    localparam logic [1:0] S_I = 2'b00, S_R = 2'b01, S_P = 2'b10, S_O = 2'b11;
    localparam logic [3:0] D_U = 4'b1000, D_D = 4'b0100, D_L = 4'b0010, D_R = 4'b0001;

    logic       clk = 1'b0;
    logic       nRst = 1'b0, goodColl = 1'b0, badColl = 1'b0, button = 1'b0;
    logic [3:0] direction = 4'b0000;

    logic [1:0] state, state2;
    logic [3:0] cur_dir, cur_dir2;
    logic       move_tick, move_tick2, grow, grow2, game_over, game_over2;
    logic [7:0] score;
    logic [1:0] score2;
    logic [6:0] length, length2;

    snake_game_ctrl #(.TICK_DIV(4), .INIT_LEN(3), .MAX_LEN(64), .SCORE_W(8)) dut (
        .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl), .button(button),
        .direction(direction), .state(state), .cur_dir(cur_dir), .move_tick(move_tick),
        .grow(grow), .score(score), .length(length), .game_over(game_over));

    snake_game_ctrl #(.TICK_DIV(4), .INIT_LEN(3), .MAX_LEN(64), .SCORE_W(2)) dut2 (
        .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl), .button(button),
        .direction(direction), .state(state2), .cur_dir(cur_dir2), .move_tick(move_tick2),
        .grow(grow2), .score(score2), .length(length2), .game_over(game_over2));

    always #5 clk = ~clk;

    typedef struct {
        bit         chk;
        logic [1:0] st;
        logic [3:0] dir;
        logic       mt;
        logic       gr;
        logic [7:0] sc;
        logic [1:0] sc2;
        logic [6:0] len;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one clock cycle of inputs and queue the outputs expected after that edge
    task automatic drive(input logic rn, g, b, btn, input logic [3:0] d, input bit c,
                         input logic [1:0] st, input logic [3:0] dir, input logic mt, gr,
                         input logic [7:0] sc, input logic [6:0] len);
        exp_t e;
        @(negedge clk);
        nRst = rn; goodColl = g; badColl = b; button = btn; direction = d;
        e.chk = c; e.st = st; e.dir = dir; e.mt = mt; e.gr = gr;
        e.sc = sc; e.sc2 = (sc > 8'd3) ? 2'd3 : sc[1:0]; e.len = len;
        q.push_back(e);
    endtask

    task automatic cyc(input logic rn, g, b, btn, input logic [3:0] d,
                       input logic [1:0] st, input logic [3:0] dir, input logic mt, gr,
                       input logic [7:0] sc, input logic [6:0] len);
        drive(rn, g, b, btn, d, 1'b1, st, dir, mt, gr, sc, len);
    endtask

    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            if (mon_e.chk) begin
                check("state",      32'(state),      32'(mon_e.st));
                check("cur_dir",    32'(cur_dir),    32'(mon_e.dir));
                check("move_tick",  32'(move_tick),  32'(mon_e.mt));
                check("grow",       32'(grow),       32'(mon_e.gr));
                check("score",      32'(score),      32'(mon_e.sc));
                check("length",     32'(length),     32'(mon_e.len));
                check("game_over",  32'(game_over),  32'(mon_e.st == S_O));
                check("score_w2",   32'(score2),     32'(mon_e.sc2));
                check("state_w2",   32'(state2),     32'(mon_e.st));
                check("cur_dir_w2", 32'(cur_dir2),   32'(mon_e.dir));
                check("tick_w2",    32'(move_tick2), 32'(mon_e.mt));
                check("grow_w2",    32'(grow2),      32'(mon_e.gr));
                check("length_w2",  32'(length2),    32'(mon_e.len));
                check("over_w2",    32'(game_over2), 32'(mon_e.st == S_O));
            end
        end
    end

    initial begin
        // reset, then IDLE ignores food and direction
        cyc(0,0,0,0,0,   S_I, D_R, 0,0, 0, 3);
        cyc(0,0,0,0,0,   S_I, D_R, 0,0, 0, 3);
        cyc(1,1,0,0,0,   S_I, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,D_U, S_I, D_R, 0,0, 0, 3);
        // start; first tick four cycles later
        cyc(1,0,0,1,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 1,0, 0, 3);
        // reversing and multi-hot turns are dropped
        cyc(1,0,0,0,D_L,     S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,4'b1100, S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,       S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,       S_R, D_R, 1,0, 0, 3);
        // UP then DOWN in one step: last one commits at the tick
        cyc(1,0,0,0,D_U, S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,D_D, S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_D, 1,0, 0, 3);
        // UP now reverses DOWN
        cyc(1,0,0,0,D_U, S_R, D_D, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_D, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_D, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_D, 1,0, 0, 3);
        // pulse on commit edge is judged against the pre-commit heading
        cyc(1,0,0,0,D_R, S_R, D_D, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_D, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_D, 0,0, 0, 3);
        cyc(1,0,0,0,D_U, S_R, D_R, 1,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,D_U, S_R, D_R, 1,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_U, 1,0, 0, 3);
        // food: score/length/grow, 2-bit score saturates at 3
        cyc(1,1,0,0,0,   S_R, D_U, 0,1, 1, 4);
        cyc(1,1,0,0,0,   S_R, D_U, 0,1, 2, 5);
        cyc(1,1,0,0,0,   S_R, D_U, 0,1, 3, 6);
        cyc(1,1,0,0,0,   S_R, D_U, 1,1, 4, 7);
        cyc(1,1,0,0,0,   S_R, D_U, 0,1, 5, 8);
        cyc(1,0,0,0,0,   S_R, D_U, 0,0, 5, 8);
        // pause at counter=2: everything frozen, events ignored
        cyc(1,0,0,1,0,   S_P, D_U, 0,0, 5, 8);
        cyc(1,1,0,0,0,   S_P, D_U, 0,0, 5, 8);
        cyc(1,0,1,0,0,   S_P, D_U, 0,0, 5, 8);
        cyc(1,0,0,0,D_R, S_P, D_U, 0,0, 5, 8);
        cyc(1,0,0,0,0,   S_P, D_U, 0,0, 5, 8);
        cyc(1,0,0,1,0,   S_R, D_U, 0,0, 5, 8);
        cyc(1,0,0,0,0,   S_R, D_U, 0,0, 5, 8);
        cyc(1,0,0,0,0,   S_R, D_U, 1,0, 5, 8);
        // badColl beats goodColl; OVER holds score until the next start
        cyc(1,1,1,0,0,   S_O, D_U, 0,0, 5, 8);
        cyc(1,1,0,0,0,   S_O, D_U, 0,0, 5, 8);
        cyc(1,0,0,1,0,   S_I, D_U, 0,0, 5, 8);
        cyc(1,0,0,1,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 1,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        // badColl on the would-be tick cycle suppresses move_tick
        cyc(1,0,1,0,0,   S_O, D_R, 0,0, 0, 3);
        cyc(1,0,0,1,0,   S_I, D_R, 0,0, 0, 3);
        cyc(1,0,0,1,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,1,0,0,0,   S_R, D_R, 0,1, 1, 4);
        cyc(1,0,0,0,D_U, S_R, D_R, 0,0, 1, 4);
        // reset mid-game
        cyc(0,1,0,0,0,   S_I, D_R, 0,0, 0, 3);
        cyc(1,0,0,1,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 0, 3);
        cyc(1,0,0,0,0,   S_R, D_R, 1,0, 0, 3);
        // 70 food pulses: length saturates at MAX_LEN=64, score reaches 70
        for (int i = 0; i < 69; i++) begin
            drive(1,1,0,0,0, 1'b0, S_R, D_R, 0,0, 0, 3);
        end
        cyc(1,1,0,0,0,   S_R, D_R, 0,1, 70, 64);
        cyc(1,0,0,0,0,   S_R, D_R, 0,0, 70, 64);

        @(negedge clk);
        goodColl = 1'b0; badColl = 1'b0; button = 1'b0; direction = 4'b0000;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
